// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze cell RAM and its scheduler.
//   MAZE_DIM / MAZE_CELLS / CELL_ADDR_W : maze geometry (64x64, 4096 cells)
//   req_id_e                            : requester IDs (display/carver/player)
//   WALL / PATH                         : cell encoding stored in the RAM
//   cell_addr()                         : x + 64*y packed into a cell address
//   sat_inc16()                         : 16-bit saturating increment
// -----------------------------------------------------------------------------
package maze_pkg;

  localparam int MAZE_DIM    = 64;
  localparam int MAZE_CELLS  = 4096;
  localparam int CELL_ADDR_W = 12;

  typedef enum logic [1:0] {
    REQ_DISP = 2'd0,
    REQ_CARV = 2'd1,
    REQ_PLYR = 2'd2
  } req_id_e;

  localparam logic WALL = 1'b1;
  localparam logic PATH = 1'b0;

  // Same bit ordering as the flat maze_data vector: y in the upper bits.
  function automatic logic [CELL_ADDR_W-1:0] cell_addr(input logic [5:0] x,
                                                       input logic [5:0] y);
    return {y, x};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/maze_rr_arb2.sv
// -----------------------------------------------------------------------------
// maze_rr_arb2
// Two-way round-robin arbiter between carver and player.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_c_i        : carver eligible
//   req_p_i        : player eligible
//   grant_i        : the low-priority slot was actually granted this cycle
//   pick_c_o       : carver is the round-robin choice
//   pick_p_o       : player is the round-robin choice
// The last_lo pointer resets to player so the carver wins the first tie.
// -----------------------------------------------------------------------------
module maze_rr_arb2
  import maze_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_c_i,
  input  logic req_p_i,
  input  logic grant_i,
  output logic pick_c_o,
  output logic pick_p_o
);

  req_id_e last_q, last_d;

  always_comb begin
    pick_c_o = req_c_i && (!req_p_i || (last_q == REQ_PLYR));
    pick_p_o = req_p_i && !pick_c_o;
    last_d   = last_q;
    if (grant_i && pick_c_o) last_d = REQ_CARV;
    else if (grant_i && pick_p_o) last_d = REQ_PLYR;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= REQ_PLYR;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/maze_mem_scheduler.sv
// -----------------------------------------------------------------------------
// maze_mem_scheduler
// Shares the single-port 4096x1 maze cell RAM between display (read-only),
// carver (r/w) and player (r/w).
//   clk, reset                 : clock, synchronous active-high reset
//   disp_req/addr, disp_gnt    : display read port (top priority)
//   carv_req/we/addr/wdata/gnt : carver port
//   plyr_req/we/addr/wdata/gnt : player port
//   carve_lock                 : holds off new player writes
//   rd_data, *_rvalid          : shared read data, valid 2 cycles after grant
//   mem_addr/we/wdata          : registered RAM drive
//   mem_rdata                  : RAM read data (1-cycle latency)
// Optional: MAZE_MEM_SCHED_STATS_EN adds stat_clr and saturating 16-bit grant
// counters stat_disp/stat_carv/stat_plyr.
// -----------------------------------------------------------------------------
module maze_mem_scheduler
  import maze_pkg::*;
#(
  parameter int ADDR_W       = CELL_ADDR_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  input  logic              carv_req,
  input  logic              carv_we,
  input  logic [ADDR_W-1:0] carv_addr,
  input  logic              carv_wdata,
  output logic              carv_gnt,
  input  logic              plyr_req,
  input  logic              plyr_we,
  input  logic [ADDR_W-1:0] plyr_addr,
  input  logic              plyr_wdata,
  output logic              plyr_gnt,
  input  logic              carve_lock,
  output logic              rd_data,
  output logic              disp_rvalid,
  output logic              carv_rvalid,
  output logic              plyr_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
`ifdef MAZE_MEM_SCHED_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_disp,
  output logic [15:0]       stat_carv,
  output logic [15:0]       stat_plyr,
`endif
  input  logic              mem_rdata
);

  logic              carv_elig, plyr_elig, any_lo, forced;
  logic              pick_c, pick_p, lo_gnt;
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_wdata_q, mem_wdata_d;
  // Read-issue pipeline, bit order {plyr, carv, disp}: s1 = RAM access cycle,
  // s2 = data-return cycle.
  logic [2:0]        rd_s1_q, rd_s1_d, rd_s2_q;

  assign carv_elig = carv_req;
  assign plyr_elig = plyr_req && !(plyr_we && carve_lock);
  assign any_lo    = carv_elig || plyr_elig;
  // Counter can sit at the limit while the only low-priority request has just
  // become ineligible (lock rose); display then proceeds normally.
  assign forced    = (starve_q == 8'(STARVE_LIMIT)) && any_lo;

  maze_rr_arb2 u_arb (
    .clk_i    (clk),
    .reset_i  (reset),
    .req_c_i  (carv_elig),
    .req_p_i  (plyr_elig),
    .grant_i  (lo_gnt),
    .pick_c_o (pick_c),
    .pick_p_o (pick_p)
  );

  always_comb begin
    disp_gnt = 1'b0;
    lo_gnt   = 1'b0;
    if (!reset) begin
      if (forced)        lo_gnt   = 1'b1;
      else if (disp_req) disp_gnt = 1'b1;
      else if (any_lo)   lo_gnt   = 1'b1;
    end
    carv_gnt = lo_gnt && pick_c;
    plyr_gnt = lo_gnt && pick_p;

    if (lo_gnt || !any_lo) starve_d = '0;
    else if (disp_gnt)     starve_d = starve_q + 8'd1;
    else                   starve_d = starve_q;

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (disp_gnt) begin
      mem_addr_d  = disp_addr;
      mem_wdata_d = PATH;
    end else if (carv_gnt) begin
      mem_addr_d  = carv_addr;
      mem_we_d    = carv_we;
      mem_wdata_d = carv_wdata;
    end else if (plyr_gnt) begin
      mem_addr_d  = plyr_addr;
      mem_we_d    = plyr_we;
      mem_wdata_d = plyr_wdata;
    end
    rd_s1_d = {plyr_gnt && !plyr_we, carv_gnt && !carv_we, disp_gnt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 1'b0;
      rd_s1_q     <= '0;
      rd_s2_q     <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s1_q;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = rd_s2_q[0];
  assign carv_rvalid = rd_s2_q[1];
  assign plyr_rvalid = rd_s2_q[2];
  assign rd_data     = (|rd_s2_q) ? mem_rdata : 1'b0;

`ifdef MAZE_MEM_SCHED_STATS_EN
  logic [15:0] stat_disp_q, stat_carv_q, stat_plyr_q;

  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_disp_q <= '0;
      stat_carv_q <= '0;
      stat_plyr_q <= '0;
    end else begin
      if (disp_gnt) stat_disp_q <= sat_inc16(stat_disp_q);
      if (carv_gnt) stat_carv_q <= sat_inc16(stat_carv_q);
      if (plyr_gnt) stat_plyr_q <= sat_inc16(stat_plyr_q);
    end
  end

  assign stat_disp = stat_disp_q;
  assign stat_carv = stat_carv_q;
  assign stat_plyr = stat_plyr_q;
`endif

endmodule

// File: tb/tb_maze_mem_scheduler.sv
// -----------------------------------------------------------------------------
// tb_maze_mem_scheduler
// Directed bench for maze_mem_scheduler with a behavioural 4096x1 RAM
// (1-cycle read latency). RAM content starts as addr[0]^addr[3].
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
// -----------------------------------------------------------------------------
module tb_maze_mem_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [11:0] disp_addr;
  logic        disp_gnt;
  logic        carv_req, carv_we, carv_wdata, carv_gnt;
  logic [11:0] carv_addr;
  logic        plyr_req, plyr_we, plyr_wdata, plyr_gnt;
  logic [11:0] plyr_addr;
  logic        carve_lock;
  logic        rd_data, disp_rvalid, carv_rvalid, plyr_rvalid;
  logic [11:0] mem_addr;
  logic        mem_we, mem_wdata;
  logic        mem_rdata;
`ifdef MAZE_MEM_SCHED_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_disp, stat_carv, stat_plyr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  maze_mem_scheduler #(.ADDR_W(12), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .carv_req    (carv_req),
    .carv_we     (carv_we),
    .carv_addr   (carv_addr),
    .carv_wdata  (carv_wdata),
    .carv_gnt    (carv_gnt),
    .plyr_req    (plyr_req),
    .plyr_we     (plyr_we),
    .plyr_addr   (plyr_addr),
    .plyr_wdata  (plyr_wdata),
    .plyr_gnt    (plyr_gnt),
    .carve_lock  (carve_lock),
    .rd_data     (rd_data),
    .disp_rvalid (disp_rvalid),
    .carv_rvalid (carv_rvalid),
    .plyr_rvalid (plyr_rvalid),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
`ifdef MAZE_MEM_SCHED_STATS_EN
    .stat_clr    (stat_clr),
    .stat_disp   (stat_disp),
    .stat_carv   (stat_carv),
    .stat_plyr   (stat_plyr),
`endif
    .mem_rdata   (mem_rdata)
  );

  // Behavioural RAM
  logic ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] a;
      a = 12'(i);
      ram[i] = a[0] ^ a[3];
    end
    mem_rdata = 1'b0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    carv_req = 1'b0; carv_we = 1'b0; carv_addr = '0; carv_wdata = 1'b0;
    plyr_req = 1'b0; plyr_we = 1'b0; plyr_addr = '0; plyr_wdata = 1'b0;
    carve_lock = 1'b0;
`ifdef MAZE_MEM_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) next_cycle();
    settle();
    check_eq("rst_gnts", {disp_gnt, carv_gnt, plyr_gnt}, 3'b000);
    check_eq("rst_rvalid", {disp_rvalid, carv_rvalid, plyr_rvalid}, 3'b000);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 12'h000);
    check_eq("rst_mem_wdata", mem_wdata, 1'b0);
    check_eq("rst_rd_data", rd_data, 1'b0);

    // Carver write of PATH to 0x041, then player reads it back
    next_cycle();
    reset = 1'b0;
    carv_req = 1'b1; carv_we = 1'b1; carv_addr = 12'h041; carv_wdata = 1'b0;
    settle();
    check_eq("t1_carv_gnt", carv_gnt, 1'b1);
    check_eq("t1_other_gnt", {disp_gnt, plyr_gnt}, 2'b00);
    next_cycle();
    carv_req = 1'b0;
    settle();
    check_eq("t1_mem_we", mem_we, 1'b1);
    check_eq("t1_mem_addr", mem_addr, 12'h041);
    check_eq("t1_mem_wdata", mem_wdata, 1'b0);
    next_cycle();
    plyr_req = 1'b1; plyr_we = 1'b0; plyr_addr = 12'h041;
    settle();
    check_eq("t1_plyr_gnt", plyr_gnt, 1'b1);
    check_eq("t1_idle_we", mem_we, 1'b0);
    next_cycle();
    plyr_req = 1'b0;
    settle();
    check_eq("t1_rvalid_n1", plyr_rvalid, 1'b0);
    check_eq("t1_rd_addr", mem_addr, 12'h041);
    next_cycle();
    settle();
    check_eq("t1_rvalid_n2", {disp_rvalid, carv_rvalid, plyr_rvalid}, 3'b001);
    check_eq("t1_rd_data", rd_data, 1'b0);
    next_cycle();
    settle();
    check_eq("t1_rvalid_n3", plyr_rvalid, 1'b0);

    // Continuous carver + player contention: C,P,C,P,...
    next_cycle();
    carv_req = 1'b1; carv_we = 1'b0; carv_addr = 12'h200;
    plyr_req = 1'b1; plyr_we = 1'b0; plyr_addr = 12'h201;
    for (int i = 0; i < 6; i++) begin
      settle();
      check_eq($sformatf("t2_carv_gnt%0d", i), carv_gnt, ((i % 2) == 0));
      check_eq($sformatf("t2_plyr_gnt%0d", i), plyr_gnt, ((i % 2) == 1));
      next_cycle();
    end
    carv_req = 1'b0; plyr_req = 1'b0;

    // Display held for 20 cycles against a pending carver
    disp_req = 1'b1; disp_addr = 12'h300;
    carv_req = 1'b1; carv_we = 1'b0; carv_addr = 12'h301;
    for (int i = 1; i <= 20; i++) begin
      settle();
      check_eq($sformatf("t3_disp_gnt%0d", i), disp_gnt, (i != 9));
      check_eq($sformatf("t3_carv_gnt%0d", i), carv_gnt, (i == 9));
      next_cycle();
      if (i == 9) carv_req = 1'b0;
    end
    disp_req = 1'b0;

    // Carve lock holds off a player write, not a player read
    carve_lock = 1'b1;
    plyr_req = 1'b1; plyr_we = 1'b1; plyr_addr = 12'h0C3; plyr_wdata = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("t4_locked_gnt%0d", i), plyr_gnt, 1'b0);
      next_cycle();
    end
    settle();
    check_eq("t4_locked_we", mem_we, 1'b0);
    next_cycle();
    carve_lock = 1'b0;
    settle();
    check_eq("t4_unlock_gnt", plyr_gnt, 1'b1);
    next_cycle();
    plyr_req = 1'b0;
    settle();
    check_eq("t4_mem_we", mem_we, 1'b1);
    check_eq("t4_mem_addr", mem_addr, 12'h0C3);
    check_eq("t4_mem_wdata", mem_wdata, 1'b0);
    next_cycle();
    carve_lock = 1'b1;
    plyr_req = 1'b1; plyr_we = 1'b0; plyr_addr = 12'h0C3;
    settle();
    check_eq("t4_read_lock_gnt", plyr_gnt, 1'b1);
    next_cycle();
    plyr_req = 1'b0; carve_lock = 1'b0;
    next_cycle();
    settle();
    check_eq("t4_rvalid", plyr_rvalid, 1'b1);
    check_eq("t4_rd_data", rd_data, 1'b0);
    next_cycle();

    // Four back-to-back display reads of 0x100..0x103 (data 0,1,0,1)
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        disp_req = 1'b1; disp_addr = 12'h100 + 12'(k);
      end else begin
        disp_req = 1'b0;
      end
      settle();
      check_eq($sformatf("t5_disp_gnt%0d", k), disp_gnt, (k < 4));
      if (k >= 2 && k < 6) begin
        check_eq($sformatf("t5_rvalid%0d", k), disp_rvalid, 1'b1);
        check_eq($sformatf("t5_rd_data%0d", k), rd_data, (((k - 2) % 2) == 1));
      end else begin
        check_eq($sformatf("t5_rvalid%0d", k), disp_rvalid, 1'b0);
      end
      next_cycle();
    end

    // Reset after the second of two display reads: no further rvalid
    disp_req = 1'b1; disp_addr = 12'h101;
    next_cycle();
    disp_addr = 12'h103;
    next_cycle();
    disp_req = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("t6_rvalid%0d", i), disp_rvalid, 1'b0);
      next_cycle();
    end
    check_eq("t6_mem_addr", mem_addr, 12'h000);

`ifdef MAZE_MEM_SCHED_STATS_EN
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    carv_req = 1'b1; carv_we = 1'b0; carv_addr = 12'h010;
    repeat (5) next_cycle();
    carv_req = 1'b0;
    settle();
    check_eq("st_carv5", stat_carv, 16'd5);
    check_eq("st_disp0", stat_disp, 16'd0);
    next_cycle();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    settle();
    check_eq("st_clr", stat_carv, 16'd0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
